// File: rtl/countdown_ctrl.sv
// countdown_ctrl: two-digit BCD countdown timer with start/pause and clear
// push-buttons, a programmable tick prescaler and a DONE blink strobe.
module countdown_ctrl #(
    parameter int TICK_DIV = 4194304,
    parameter int SYNC_EN  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_n,
    input  logic       clear_n,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    output logic [3:0] tens_bcd,
    output logic [3:0] ones_bcd,
    output logic [1:0] state,
    output logic       running,
    output logic       done,
    output logic       blink
);

    localparam int             PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    // ------------------------------------------------------------------
    // Button conditioning: bit 0 = start, bit 1 = clear (both active-low)
    // ------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] lvl;        // conditioned button level
    logic       lvl_valid;  // lvl reflects samples taken after reset

    assign btn_raw = {clear_n, start_n};

    generate
        if (SYNC_EN != 0) begin : g_sync
            logic [1:0] s1_q, s1_d;
            logic [1:0] s2_q, s2_d;
            logic [1:0] fill_q, fill_d;

            // Two-stage synchronizer plus a fill marker tracking when the
            // second stage holds a real post-reset sample.
            always_comb begin
                s1_d   = btn_raw;
                s2_d   = s1_q;
                fill_d = {fill_q[0], 1'b1};
            end

            // Synchronizer flops reset high so nothing looks pressed.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    s1_q   <= 2'b11;
                    s2_q   <= 2'b11;
                    fill_q <= 2'b00;
                end else begin
                    s1_q   <= s1_d;
                    s2_q   <= s2_d;
                    fill_q <= fill_d;
                end
            end

            assign lvl       = s2_q;
            assign lvl_valid = fill_q[1];
        end else begin : g_direct
            assign lvl       = btn_raw;
            assign lvl_valid = 1'b1;
        end
    endgenerate

    logic [1:0] prev_q, prev_d;
    logic [1:0] armed_q, armed_d;
    logic [1:0] press;

    // Falling-edge detect. A button is armed only once it has been seen
    // released after reset, so a button held through reset never fires.
    always_comb begin
        prev_d  = lvl;
        armed_d = armed_q | ({2{lvl_valid}} & lvl);
        press   = armed_q & prev_q & ~lvl;
    end

    // Edge register and arm flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q  <= 2'b11;
            armed_q <= 2'b00;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    logic press_start, press_clear;
    assign press_start = press[0];
    assign press_clear = press[1];

    // ------------------------------------------------------------------
    // Countdown datapath and FSM
    // ------------------------------------------------------------------
    logic [3:0] tens_p, ones_p;
    assign tens_p = (preset_tens > 4'd9) ? 4'd9 : preset_tens;
    assign ones_p = (preset_ones > 4'd9) ? 4'd9 : preset_ones;

    logic [1:0]    state_q, state_d;
    logic [3:0]    tens_q, tens_d, ones_q, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          blink_q, blink_d;
    logic          running_q, running_d;
    logic          done_q, done_d;

    logic       counting, tick;
    logic [3:0] dec_tens, dec_ones;
    logic       dec_zero;

    // Next-state logic: prescaler, BCD decrement, FSM, blink.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
        blink_d = blink_q;

        counting = (state_q == ST_RUN) || (state_q == ST_DONE);
        tick     = counting && (presc_q == PRE_LAST);

        // Borrow from tens when ones is 0; RUN never decrements from 00.
        dec_ones = (ones_q != 4'd0) ? (ones_q - 4'd1) : 4'd9;
        dec_tens = (ones_q != 4'd0) ? tens_q : (tens_q - 4'd1);
        dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0);

        if (counting)
            presc_d = tick ? '0 : (presc_q + PW'(1));

        case (state_q)
            ST_IDLE: begin
                tens_d  = tens_p;
                ones_d  = ones_p;
                presc_d = '0;
                blink_d = 1'b0;
                if (press_start)
                    state_d = ((tens_p == 4'd0) && (ones_p == 4'd0)) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                // Tick is applied first; a coincident start then pauses
                // unless the tick already finished the count.
                if (tick) begin
                    tens_d = dec_tens;
                    ones_d = dec_ones;
                end
                if (tick && dec_zero)
                    state_d = ST_DONE;
                else if (press_start)
                    state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (press_start)
                    state_d = ST_RUN;
            end
            default: begin  // ST_DONE
                tens_d = 4'd0;
                ones_d = 4'd0;
                if (tick)
                    blink_d = ~blink_q;
                if (press_start) begin
                    state_d = ST_IDLE;
                    blink_d = 1'b0;
                    presc_d = '0;
                    tens_d  = tens_p;
                    ones_d  = ones_p;
                end
            end
        endcase

        // Clear beats everything, including a simultaneous start.
        if (press_clear) begin
            state_d = ST_IDLE;
            presc_d = '0;
            blink_d = 1'b0;
            tens_d  = tens_p;
            ones_d  = ones_p;
        end

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // Main state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            tens_q    <= tens_p;
            ones_q    <= ones_p;
            presc_q   <= '0;
            blink_q   <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            presc_q   <= presc_d;
            blink_q   <= blink_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign tens_bcd = tens_q;
    assign ones_bcd = ones_q;
    assign state    = state_q;
    assign running  = running_q;
    assign done     = done_q;
    assign blink    = blink_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with TICK_DIV=4, SYNC_EN=1.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_countdown_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_n, clear_n;
    logic [3:0] preset_tens, preset_ones;
    logic [3:0] tens_bcd, ones_bcd;
    logic [1:0] state;
    logic       running, done, blink;

    int n_chk = 0;
    int n_err = 0;

    countdown_ctrl #(.TICK_DIV(4), .SYNC_EN(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_n     (start_n),
        .clear_n     (clear_n),
        .preset_tens (preset_tens),
        .preset_ones (preset_ones),
        .tens_bcd    (tens_bcd),
        .ones_bcd    (ones_bcd),
        .state       (state),
        .running     (running),
        .done        (done),
        .blink       (blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one or both buttons low for 'hold' cycles, then release.
    task automatic press(input logic s, input logic c, input int hold);
        if (s) start_n = 1'b0;
        if (c) clear_n = 1'b0;
        cyc(hold);
        start_n = 1'b1;
        clear_n = 1'b1;
    endtask

    function automatic logic [7:0] bcd(input int k);
        logic [3:0] t, o;
        t = 4'(k / 10);
        o = 4'(k % 10);
        return {t, o};
    endfunction

    initial begin
        reset       = 1'b0;
        start_n     = 1'b1;
        clear_n     = 1'b1;
        preset_tens = 4'd1;
        preset_ones = 4'd2;
        cyc(2);
        check("rst_state",   state,   2'b00);
        check("rst_running", running, 1'b0);
        check("rst_done",    done,    1'b0);
        check("rst_blink",   blink,   1'b0);
        check("rst_digits",  {tens_bcd, ones_bcd}, 8'h12);
        reset = 1'b1;
        cyc(5);

        // Preset 12 counts down to 00 then DONE.
        press(1, 0, 1);
        cyc(2);
        check("run_state",   state,   2'b01);
        check("run_running", running, 1'b1);
        check("run_start",   {tens_bcd, ones_bcd}, 8'h12);
        for (int k = 11; k >= 0; k--) begin
            cyc(3);
            check("cnt_hold", {tens_bcd, ones_bcd}, bcd(k + 1));
            cyc(1);
            check("cnt_tick", {tens_bcd, ones_bcd}, bcd(k));
        end
        check("end_state",   state,   2'b11);
        check("end_done",    done,    1'b1);
        check("end_running", running, 1'b0);
        check("end_blink0",  blink,   1'b0);
        cyc(3);
        check("end_blink_hold", blink, 1'b0);
        cyc(1);
        check("end_blink_tgl",  blink, 1'b1);
        press(1, 0, 1);
        cyc(2);
        check("done_to_idle",   state, 2'b00);
        check("done_idle_blnk", blink, 1'b0);
        check("done_idle_dig",  {tens_bcd, ones_bcd}, 8'h12);

        // Preset 05: pause after 2 ticks, resume with held prescaler.
        preset_tens = 4'd0;
        preset_ones = 4'd5;
        cyc(1);
        check("idle_follow", {tens_bcd, ones_bcd}, 8'h05);
        press(1, 0, 1);
        cyc(2);
        check("p_run", state, 2'b01);
        cyc(4);
        check("p_t1", {tens_bcd, ones_bcd}, 8'h04);
        cyc(4);
        check("p_t2", {tens_bcd, ones_bcd}, 8'h03);
        press(1, 0, 1);
        cyc(2);
        check("p_pause", state, 2'b10);
        cyc(20);
        check("p_pause_hold", state,   2'b10);
        check("p_pause_dig",  {tens_bcd, ones_bcd}, 8'h03);
        check("p_pause_run",  running, 1'b0);
        press(1, 0, 1);
        cyc(2);
        check("p_resume",     state, 2'b01);
        check("p_resume_dig", {tens_bcd, ones_bcd}, 8'h03);
        cyc(1);
        check("p_resume_tick", {tens_bcd, ones_bcd}, 8'h02);
        cyc(3);
        check("p_next_hold",   {tens_bcd, ones_bcd}, 8'h02);
        cyc(1);
        check("p_next_tick",   {tens_bcd, ones_bcd}, 8'h01);
        press(0, 1, 1);
        cyc(2);
        check("p_clear_state", state, 2'b00);
        check("p_clear_dig",   {tens_bcd, ones_bcd}, 8'h05);

        // Preset 00: straight to DONE, blink every 4 cycles.
        preset_ones = 4'd0;
        cyc(1);
        press(1, 0, 1);
        cyc(2);
        check("z_done",    state,   2'b11);
        check("z_done_o",  done,    1'b1);
        check("z_running", running, 1'b0);
        cyc(3);
        check("z_blink_a", blink, 1'b0);
        cyc(1);
        check("z_blink_b", blink, 1'b1);
        cyc(3);
        check("z_blink_c", blink, 1'b1);
        cyc(1);
        check("z_blink_d", blink, 1'b0);
        press(1, 0, 1);
        cyc(2);
        check("z_idle",       state, 2'b00);
        check("z_idle_blink", blink, 1'b0);
        check("z_idle_done",  done,  1'b0);

        // Start and clear together during RUN: clear wins.
        preset_tens = 4'd1;
        preset_ones = 4'd2;
        cyc(1);
        press(1, 0, 1);
        cyc(2);
        check("sc_run", state, 2'b01);
        cyc(1);
        press(1, 1, 1);
        cyc(2);
        check("sc_idle",    state,   2'b00);
        check("sc_running", running, 1'b0);
        check("sc_digits",  {tens_bcd, ones_bcd}, 8'h12);
        preset_tens = 4'd3;
        preset_ones = 4'd7;
        cyc(1);
        check("sc_follow", {tens_bcd, ones_bcd}, 8'h37);

        // Clamp non-BCD preset; long hold gives one transition.
        preset_tens = 4'hC;
        preset_ones = 4'hF;
        cyc(1);
        check("clamp_99", {tens_bcd, ones_bcd}, 8'h99);
        press(1, 0, 50);
        check("hold_run",    state, 2'b01);
        check("hold_digits", {tens_bcd, ones_bcd}, 8'h88);
        cyc(5);
        check("hold_still_run", running, 1'b1);
        press(0, 1, 1);
        cyc(2);
        check("hold_clear", state, 2'b00);

        // Reset mid-RUN at 07; start held across reset deassertion.
        preset_tens = 4'd0;
        preset_ones = 4'd9;
        cyc(1);
        press(1, 0, 1);
        cyc(2);
        check("mr_run", state, 2'b01);
        cyc(4);
        check("mr_08", {tens_bcd, ones_bcd}, 8'h08);
        cyc(4);
        check("mr_07", {tens_bcd, ones_bcd}, 8'h07);
        cyc(1);
        reset   = 1'b0;
        start_n = 1'b0;
        cyc(1);
        check("mr_idle",    state,   2'b00);
        check("mr_running", running, 1'b0);
        check("mr_digits",  {tens_bcd, ones_bcd}, 8'h09);
        cyc(1);
        reset = 1'b1;
        cyc(10);
        check("mr_held_no_tr", state, 2'b00);
        start_n = 1'b1;
        cyc(5);
        check("mr_release_no_tr", state, 2'b00);
        press(1, 0, 1);
        cyc(2);
        check("mr_first_press", state, 2'b01);
        press(0, 1, 1);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
